motor_output: RTL and testbench

Parametrised multi-channel ESC output generator for the flight core. It takes per-motor throttle commands from the mixer and produces frame-synchronous standard PWM or OneShot125 pulses on `NUM_MOTORS` pins. Disarm forcing, command clamping and a frame-count failsafe are built in. It replaces the fixed four-pin motor drive and sits between the mixer and the `MOTOR_n` pads.

---
 rtl/motor_output.sv | 142 ++++++++++++++
 tb/tb_motor_output.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_output.sv
// rtl/motor_output.sv - frame-synchronous multi-channel PWM / OneShot125 ESC output generator
// Commands are captured into shadow registers and promoted to per-channel pulse lengths at each frame boundary.
module motor_output #(
    parameter int BASE_FREQ      = 16_000_000,
    parameter int NUM_MOTORS     = 4,
    parameter int VALUE_BITS     = 11,
    parameter int MAX_VALUE      = 1000,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [1:0]                       MODE,
    input  logic                             ARMED,
    input  logic [NUM_MOTORS*VALUE_BITS-1:0] VALUES,
    input  logic                             VALUES_VALID,
    output logic [NUM_MOTORS-1:0]            MOTOR_OUT,
    output logic                             FRAME_START,
    output logic                             FAILSAFE
);

    localparam int CYC_PER_US = BASE_FREQ / 1_000_000;
    localparam int CW         = $clog2(2500 * CYC_PER_US + 1);

    localparam logic [CW-1:0]         PWM_LAST = CW'(2500 * CYC_PER_US - 1);
    localparam logic [CW-1:0]         OS_LAST  = CW'(500 * CYC_PER_US - 1);
    localparam logic [1:0]            MODE_PWM = 2'd0;
    localparam logic [1:0]            MODE_OS  = 2'd1;
    localparam logic [1:0]            MODE_OFF = 2'd2;
    localparam logic [VALUE_BITS-1:0] MAX_V    = VALUE_BITS'(MAX_VALUE);
    localparam logic [7:0]            TIMEOUT  = 8'(TIMEOUT_FRAMES);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [7:0]            stale_q, stale_d;
    logic                  failsafe_q, failsafe_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_MOTORS-1:0] motor_q, motor_d;
    logic [VALUE_BITS-1:0] shadow_q [NUM_MOTORS];
    logic [VALUE_BITS-1:0] shadow_d [NUM_MOTORS];
    logic [CW-1:0]         pulse_q  [NUM_MOTORS];
    logic [CW-1:0]         pulse_d  [NUM_MOTORS];
    logic [VALUE_BITS-1:0] vin_c    [NUM_MOTORS];
    logic                  boundary;

    function automatic logic [VALUE_BITS-1:0] clamp(input logic [VALUE_BITS-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // Worst case (1000+MAX_VALUE)*CYC_PER_US stays below 2500*CYC_PER_US, so CW bits never overflow;
    // the /8 is exact because CYC_PER_US is a multiple of 8.
    function automatic logic [CW-1:0] pulse_len(input logic [1:0] m, input logic [VALUE_BITS-1:0] v);
        logic [CW-1:0] base;
        base = (CW'(v) + CW'(1000)) * CW'(CYC_PER_US);
        return (m == MODE_OS) ? (base >> 3) : base;
    endfunction

    function automatic logic [CW-1:0] frame_last(input logic [1:0] m);
        return (m == MODE_PWM) ? PWM_LAST : OS_LAST;
    endfunction

    assign boundary = (cnt_q == '0);

    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            vin_c[i] = clamp(VALUES[i*VALUE_BITS +: VALUE_BITS]);
        end
    end

    always_comb begin
        cnt_d         = (cnt_q == frame_last(mode_q)) ? '0 : cnt_q + CW'(1);
        mode_d        = mode_q;
        stale_d       = stale_q;
        failsafe_d    = failsafe_q;
        frame_start_d = boundary;
        shadow_d      = shadow_q;
        pulse_d       = pulse_q;

        if (boundary) begin
            mode_d  = MODE;
            stale_d = (stale_q == TIMEOUT) ? stale_q : stale_q + 8'd1;
            // A strobe landing on the boundary feeds the new frame directly and overrides a stale failsafe.
            for (int i = 0; i < NUM_MOTORS; i++) begin
                pulse_d[i] = pulse_len(MODE,
                    (ARMED && (VALUES_VALID || !failsafe_q)) ?
                        (VALUES_VALID ? vin_c[i] : shadow_q[i]) : '0);
            end
            if (stale_d == TIMEOUT) begin
                failsafe_d = 1'b1;
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    shadow_d[i] = '0;
                end
            end
        end

        if (VALUES_VALID) begin
            stale_d    = '0;
            failsafe_d = 1'b0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                shadow_d[i] = vin_c[i];
            end
        end
    end

    // Compare against the pulse length in force for this cycle so the rise lands one cycle after cnt==0.
    always_comb begin
        motor_d = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            motor_d[i] = !mode_d[1] && (cnt_q < pulse_d[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q         <= '0;
            mode_q        <= MODE_OFF;
            stale_q       <= '0;
            failsafe_q    <= 1'b1;
            frame_start_q <= 1'b0;
            motor_q       <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                shadow_q[i] <= '0;
                pulse_q[i]  <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            stale_q       <= stale_d;
            failsafe_q    <= failsafe_d;
            frame_start_q <= frame_start_d;
            motor_q       <= motor_d;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                shadow_q[i] <= shadow_d[i];
                pulse_q[i]  <= pulse_d[i];
            end
        end
    end

    assign MOTOR_OUT   = motor_q;
    assign FRAME_START = frame_start_q;
    assign FAILSAFE    = failsafe_q;

endmodule

// File: tb/tb_motor_output.sv
// tb/tb_motor_output.sv - scoreboard bench for motor_output at 8 MHz (PWM frame 20000, OneShot/off frame 4000)
module tb_motor_output;

    localparam int NM = 4;
    localparam int VB = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic              armed;
    logic [NM*VB-1:0]  vals;
    logic              vv;
    logic [NM-1:0]     mout;
    logic              fs;
    logic              fsafe;

    always #5 clk = ~clk;

    motor_output #(
        .BASE_FREQ(8_000_000),
        .NUM_MOTORS(NM),
        .VALUE_BITS(VB),
        .MAX_VALUE(1000),
        .TIMEOUT_FRAMES(4)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .MODE(mode),
        .ARMED(armed),
        .VALUES(vals),
        .VALUES_VALID(vv),
        .MOTOR_OUT(mout),
        .FRAME_START(fs),
        .FAILSAFE(fsafe)
    );

    int errors = 0;
    int checks = 0;
    int exp_pw [NM][$];
    int exp_iv [$];
    bit mon_en = 1'b0;
    bit prev_valid = 1'b0;
    int cyc = 0;
    int prev_fs = 0;
    int run [NM];

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    task automatic set_vals(input int a, input int b, input int c, input int d);
        vals = {VB'(d), VB'(c), VB'(b), VB'(a)};
    endtask

    task automatic push_frame(input int a, input int b, input int c, input int d);
        exp_pw[0].push_back(a);
        exp_pw[1].push_back(b);
        exp_pw[2].push_back(c);
        exp_pw[3].push_back(d);
    endtask

    task automatic push_iv(input int n, input int len);
        repeat (n) exp_iv.push_back(len);
    endtask

    task automatic wait_fs();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20010; k++) begin
            @(negedge clk);
            if (fs) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout: no FRAME_START within 20010 cycles");
        end
    endtask

    // Monitor: measures pulse widths and frame-start spacing, compares against queued expectations.
    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            prev_valid = 1'b0;
            for (int ch = 0; ch < NM; ch++) run[ch] = 0;
        end else begin
            if (fs) begin
                if (prev_valid) begin
                    if (exp_iv.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_interval: unexpected frame after %0d cycles", cyc - prev_fs);
                    end else begin
                        chk("frame_interval", cyc - prev_fs, exp_iv.pop_front());
                    end
                end
                prev_fs = cyc;
                prev_valid = 1'b1;
            end
            for (int ch = 0; ch < NM; ch++) begin
                if (mout[ch]) begin
                    run[ch]++;
                end else if (run[ch] != 0) begin
                    if (exp_pw[ch].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pulse_m%0d: unexpected pulse of %0d cycles", ch, run[ch]);
                    end else begin
                        chk($sformatf("pulse_m%0d", ch), run[ch], exp_pw[ch].pop_front());
                    end
                    run[ch] = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        mode = 2'd1;
        armed = 1'b1;
        vv = 1'b0;
        set_vals(1000, 0, 1500, 200);
        repeat (3) @(negedge clk);
        chk("reset_motor", int'(mout), 0);
        chk("reset_frame_start", int'(fs), 0);
        chk("reset_failsafe", int'(fsafe), 1);

        // First boundary coincides with the strobe: OneShot, clamp of 1500, bypass of shadow.
        rst = 1'b0;
        vv = 1'b1;
        mon_en = 1'b1;
        push_frame(2000, 1000, 2000, 1200);
        @(negedge clk);
        vv = 1'b0;
        chk("first_frame_start", int'(fs), 1);
        chk("first_motor", int'(mout), 4'hF);
        chk("failsafe_cleared_first", int'(fsafe), 0);

        // During O1: request PWM, disarmed, commands 800 -> minimum pulses.
        mode = 2'd0;
        armed = 1'b0;
        set_vals(800, 800, 800, 800);
        vv = 1'b1;
        push_iv(1, 4000);
        push_frame(8000, 8000, 8000, 8000);
        @(negedge clk);
        vv = 1'b0;

        wait_fs();
        repeat (2000) @(negedge clk);
        armed = 1'b1;
        chk("mid_pulse_disarmed", int'(mout), 4'hF);
        push_iv(1, 20000);
        push_frame(9600, 12000, 14400, 16000);
        repeat (17999) @(negedge clk);
        set_vals(200, 500, 800, 1000);
        vv = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        chk("coincident_frame_start", int'(fs), 1);
        chk("coincident_failsafe", int'(fsafe), 0);

        // No further updates: failsafe at the 4th following boundary, minimum pulses after.
        mode = 2'd1;
        push_iv(1, 20000);
        repeat (4) push_frame(1200, 1500, 1800, 2000);
        push_frame(1000, 1000, 1000, 1000);
        push_iv(6, 4000);
        for (int f = 2; f <= 5; f++) begin
            wait_fs();
            chk($sformatf("failsafe_o%0d", f), int'(fsafe), int'(f == 5));
        end
        wait_fs();
        chk("failsafe_o6", int'(fsafe), 1);
        repeat (1100) @(negedge clk);
        chk("failsafe_held", int'(fsafe), 1);
        set_vals(100, 100, 100, 100);
        vv = 1'b1;
        mode = 2'd2;
        @(negedge clk);
        vv = 1'b0;
        chk("failsafe_cleared", int'(fsafe), 0);

        wait_fs();
        chk("off_motor_start", int'(mout), 0);
        mode = 2'd0;
        repeat (2000) @(negedge clk);
        chk("off_motor_mid", int'(mout), 0);

        wait_fs();
        chk("pwm_restart_motor", int'(mout), 4'hF);
        @(negedge clk);
        mon_en = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_reset_motor", int'(mout), 4'hF);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_motor", int'(mout), 0);
        chk("mid_reset_failsafe", int'(fsafe), 1);
        chk("mid_reset_frame_start", int'(fs), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_frame_start", int'(fs), 1);
        chk("post_reset_motor", int'(mout), 4'hF);

        for (int ch = 0; ch < NM; ch++) begin
            chk($sformatf("pulses_left_m%0d", ch), exp_pw[ch].size(), 0);
        end
        chk("intervals_left", exp_iv.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
